pt_walk_engine: RTL and testbench
=================================

Name: pt_walk_engine

Overview:
- Shared page-table walk engine directly downstream of the speculative TLB. It services the TLB's 8-byte-page lookup port and 32-byte-page lookup port on a miss.
- Arbitrates between the two ports, models a fixed walk latency, and returns the translation entry with a one-cycle completion pulse.
- Holds both page tables internally. A bench/firmware write port allows remapping.

Parameters:
- WALK_LAT, 4: rising edges from request acceptance to COMPLETE assertion; legal range 1..15.
- CNT_W, 16: width of the walk statistics counter.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- LOOKUP_RQST_8B  in  1  8B-page walk request, level, held until COMPLETE.
- LOOKUP_ADDR_8B  in  6  8B-page VPN (VA[8:3]).
- LOOKUP_COMPLETE_8B  out  1  one-cycle completion pulse.
- LOOKUP_RETURN_8B  out  12  {VPN[5:0], PPN[5:0]}.
- LOOKUP_RQST_32B  in  1  32B-page walk request, level.
- LOOKUP_ADDR_32B  in  4  32B-page VPN (VA[8:5]).
- LOOKUP_COMPLETE_32B  out  1  one-cycle completion pulse.
- LOOKUP_RETURN_32B  out  8  {VPN[3:0], PPN[3:0]}.
- PT_WR_EN  in  1  table write strobe.
- PT_WR_SEL  in  1  0 = 8B table, 1 = 32B table.
- PT_WR_ADDR  in  6  entry index; for 32B only bits [3:0] are used.
- PT_WR_DATA  in  6  new PPN; for 32B only bits [3:0] are used.
- BUSY  out  1  walk in progress.
- WALK_COUNT  out  CNT_W  completed walks, saturating.

Behaviour:
- Reset (async assert, sync deassert use):
  - All outputs go to 0.
  - Internal state: FSM to IDLE; round-robin pointer to 8B; both re-arm flags set.
  - Tables are reinitialised to the default mapping: 8B entry i = i | 6'b100000; 32B entry i = i | 4'b1000. The default mapping is VA with MSB forced to 1.
- Reset mid-walk aborts the walk; no COMPLETE is ever issued for it.
- FSM states:
  - IDLE: BUSY=0.
    - Port eligible = RQST high AND its re-arm flag set.
    - If one port is eligible, accept it. If both are eligible, accept the one the RR pointer names, then toggle the pointer to the other port.
    - On acceptance: latch port id and ADDR, load latency counter, set BUSY=1, clear that port's re-arm flag, go to WALK.
  - WALK: counter decrements each cycle. On the final cycle the table entry is read and the FSM goes to RESP.
  - RESP: the granted port's COMPLETE=1 for exactly one cycle, RETURN = {latched VPN, table PPN}. WALK_COUNT increments, saturating at all-ones. Next state IDLE.
- Latency: with acceptance at rising edge N, COMPLETE is high in the cycle following edge N+WALK_LAT.
  - WALK_LAT=1 means COMPLETE goes high on the edge after acceptance.
  - A request seen in IDLE can be re-accepted at the earliest 1 cycle after the RESP cycle.
- RETURN holds its value after COMPLETE until that port's next completion.
- The other port's RETURN and COMPLETE are unaffected by a walk on this port.
- Re-arm: a port's flag is set when its RQST is sampled low.
  - A requester holding RQST high past COMPLETE does not trigger a duplicate walk.
  - The flag is cleared on acceptance.
- Requests arriving while BUSY are not lost. They remain pending, since RQST is level, and are arbitrated in the next IDLE.
- ADDR changes after acceptance are ignored; the address is latched.
- Table writes:
  - Take effect at the edge where PT_WR_EN=1, in any state.
  - A write to the entry being read in the same cycle as the WALK read: the walk returns the old PPN (read-before-write).
  - A write in any earlier WALK cycle is visible to the walk.
- Only the low 6 or 4 bits are used for writes to the respective table; upper bits are ignored.
- RQST deassertion by a requester while its walk is in flight does not cancel the walk; COMPLETE still pulses.

Test Plan:
- Default mapping, 8B: reset, WALK_LAT=4, RQST_8B=1, ADDR_8B=6'h15 → COMPLETE_8B pulses once in the cycle after edge N+4, RETURN_8B=12'h575, WALK_COUNT=1.
- Simultaneous requests: both RQST high, ADDR_8B=6'h02, ADDR_32B=4'h3 → 8B served first (RETURN_8B=12'h0A2), then 32B (RETURN_32B=8'h3B). Repeating with both high again → 32B is served first.
- No duplicate: hold RQST_32B high for 20 cycles after COMPLETE → exactly one COMPLETE_32B pulse. Drop for 1 cycle, raise again → a second walk occurs.
- Remap: write PT_WR_SEL=0, ADDR=6'h07, DATA=6'h2A, then walk 8B VPN 7 → RETURN_8B=12'h1EA. A write landing on the read cycle of an in-flight walk to the same entry → old PPN returned, new PPN on the next walk.
- Reset mid-walk: assert rst_n=0 two cycles into the walk → outputs are 0 immediately, no COMPLETE. After release, the table is back to default and WALK_COUNT=0.
- WALK_LAT=1 and saturation: back-to-back 8B requests → COMPLETE one edge after each acceptance. With CNT_W=2, four walks → WALK_COUNT stays at 3.

Source files
------------

// File: rtl/pt_walk_engine.sv
// Shared page-table walk engine behind the speculative TLB: arbitrates the 8B and 32B
// miss ports, walks with a fixed latency and returns {VPN, PPN} with a one-cycle pulse.
module pt_walk_engine #(
  parameter int WALK_LAT = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             LOOKUP_RQST_8B,
  input  logic [5:0]       LOOKUP_ADDR_8B,
  output logic             LOOKUP_COMPLETE_8B,
  output logic [11:0]      LOOKUP_RETURN_8B,
  input  logic             LOOKUP_RQST_32B,
  input  logic [3:0]       LOOKUP_ADDR_32B,
  output logic             LOOKUP_COMPLETE_32B,
  output logic [7:0]       LOOKUP_RETURN_32B,
  input  logic             PT_WR_EN,
  input  logic             PT_WR_SEL,
  input  logic [5:0]       PT_WR_ADDR,
  input  logic [5:0]       PT_WR_DATA,
  output logic             BUSY,
  output logic [CNT_W-1:0] WALK_COUNT
);

  typedef enum logic [1:0] {IDLE, WALK, RESP} state_e;

  localparam logic [3:0] LAT_LOAD = 4'(WALK_LAT - 1);

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic             port_32b_q;
  logic [5:0]       vpn_q;
  logic             rr_32b_q;
  logic             rearm_8b_q;
  logic             rearm_32b_q;
  logic             cmp_8b_q;
  logic             cmp_32b_q;
  logic [11:0]      ret_8b_q;
  logic [7:0]       ret_32b_q;
  logic             busy_q;
  logic [CNT_W-1:0] count_q;

  logic [5:0] pt8_q  [64];
  logic [3:0] pt32_q [16];

  logic elig_8b;
  logic elig_32b;
  logic grant_32b;

  assign elig_8b  = LOOKUP_RQST_8B  & rearm_8b_q;
  assign elig_32b = LOOKUP_RQST_32B & rearm_32b_q;

  // Under contention the round-robin pointer decides; otherwise the lone eligible port wins.
  always_comb begin
    grant_32b = elig_32b;
    if (elig_8b && elig_32b) grant_32b = rr_32b_q;
  end

  // NOTE: the tables are flops with an async reset, because a reset must restore the default
  // VA->PA mapping; a RAM without reset could not honour that.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) pt8_q[i]  <= 6'(i) | 6'h20;
      for (int i = 0; i < 16; i++) pt32_q[i] <= 4'(i) | 4'h8;
    end else if (PT_WR_EN) begin
      if (PT_WR_SEL) pt32_q[PT_WR_ADDR[3:0]] <= PT_WR_DATA[3:0];
      else           pt8_q[PT_WR_ADDR]       <= PT_WR_DATA;
    end
  end

  // NOTE: all state uses non-blocking assignments, so the WALK read of a table entry sees the
  // value from before a same-edge write (read-before-write).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      port_32b_q  <= 1'b0;
      vpn_q       <= '0;
      rr_32b_q    <= 1'b0;
      rearm_8b_q  <= 1'b1;
      rearm_32b_q <= 1'b1;
      cmp_8b_q    <= 1'b0;
      cmp_32b_q   <= 1'b0;
      ret_8b_q    <= '0;
      ret_32b_q   <= '0;
      busy_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      cmp_8b_q  <= 1'b0;
      cmp_32b_q <= 1'b0;
      if (!LOOKUP_RQST_8B)  rearm_8b_q  <= 1'b1;
      if (!LOOKUP_RQST_32B) rearm_32b_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (elig_8b || elig_32b) begin
            port_32b_q <= grant_32b;
            vpn_q      <= grant_32b ? {2'b00, LOOKUP_ADDR_32B} : LOOKUP_ADDR_8B;
            cnt_q      <= LAT_LOAD;
            busy_q     <= 1'b1;
            state_q    <= WALK;
            if (elig_8b && elig_32b) rr_32b_q <= ~rr_32b_q;
            if (grant_32b) rearm_32b_q <= 1'b0;
            else           rearm_8b_q  <= 1'b0;
          end
        end
        WALK: begin
          if (cnt_q == 4'd0) begin
            state_q <= RESP;
            if (port_32b_q) begin
              cmp_32b_q <= 1'b1;
              ret_32b_q <= {vpn_q[3:0], pt32_q[vpn_q[3:0]]};
            end else begin
              cmp_8b_q <= 1'b1;
              ret_8b_q <= {vpn_q, pt8_q[vpn_q]};
            end
            if (count_q != {CNT_W{1'b1}}) count_q <= count_q + CNT_W'(1);
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign LOOKUP_COMPLETE_8B  = cmp_8b_q;
  assign LOOKUP_COMPLETE_32B = cmp_32b_q;
  assign LOOKUP_RETURN_8B    = ret_8b_q;
  assign LOOKUP_RETURN_32B   = ret_32b_q;
  assign BUSY                = busy_q;
  assign WALK_COUNT          = count_q;

endmodule

// File: tb/tb_pt_walk_engine.sv
// Directed bench for pt_walk_engine: default instance (WALK_LAT=4) plus a WALK_LAT=1, CNT_W=2
// instance for back-to-back latency and counter saturation.
module tb_pt_walk_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        a_rq8, a_rq32, a_wr_en, a_wr_sel;
  logic [5:0]  a_a8, a_wr_addr, a_wr_data;
  logic [3:0]  a_a32;
  logic        a_c8, a_c32, a_busy;
  logic [11:0] a_r8;
  logic [7:0]  a_r32;
  logic [15:0] a_cnt;

  logic        b_rq8, b_rq32, b_wr_en, b_wr_sel;
  logic [5:0]  b_a8, b_wr_addr, b_wr_data;
  logic [3:0]  b_a32;
  logic        b_c8, b_c32, b_busy;
  logic [11:0] b_r8;
  logic [7:0]  b_r32;
  logic [1:0]  b_cnt;

  int tests = 0;
  int failed = 0;
  int n8 = 0;
  int n32 = 0;
  int base;

  logic [11:0] b_exp_ret [4] = '{12'h020, 12'h061, 12'h0A2, 12'h0E3};
  logic [1:0]  b_exp_cnt [4] = '{2'd1, 2'd2, 2'd3, 2'd3};

  pt_walk_engine #(.WALK_LAT(4), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n),
    .LOOKUP_RQST_8B(a_rq8), .LOOKUP_ADDR_8B(a_a8),
    .LOOKUP_COMPLETE_8B(a_c8), .LOOKUP_RETURN_8B(a_r8),
    .LOOKUP_RQST_32B(a_rq32), .LOOKUP_ADDR_32B(a_a32),
    .LOOKUP_COMPLETE_32B(a_c32), .LOOKUP_RETURN_32B(a_r32),
    .PT_WR_EN(a_wr_en), .PT_WR_SEL(a_wr_sel), .PT_WR_ADDR(a_wr_addr), .PT_WR_DATA(a_wr_data),
    .BUSY(a_busy), .WALK_COUNT(a_cnt)
  );

  pt_walk_engine #(.WALK_LAT(1), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n),
    .LOOKUP_RQST_8B(b_rq8), .LOOKUP_ADDR_8B(b_a8),
    .LOOKUP_COMPLETE_8B(b_c8), .LOOKUP_RETURN_8B(b_r8),
    .LOOKUP_RQST_32B(b_rq32), .LOOKUP_ADDR_32B(b_a32),
    .LOOKUP_COMPLETE_32B(b_c32), .LOOKUP_RETURN_32B(b_r32),
    .PT_WR_EN(b_wr_en), .PT_WR_SEL(b_wr_sel), .PT_WR_ADDR(b_wr_addr), .PT_WR_DATA(b_wr_data),
    .BUSY(b_busy), .WALK_COUNT(b_cnt)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle so each high cycle is counted once.
  always @(negedge clk) begin
    if (a_c8 === 1'b1)  n8++;
    if (a_c32 === 1'b1) n32++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_c(input bit is32, input string tag);
    int k = 0;
    while (((is32 ? a_c32 : a_c8) !== 1'b1) && k < 40) begin
      tick();
      k++;
    end
    check({tag, "_complete"}, {31'd0, (is32 ? a_c32 : a_c8)}, 32'd1);
  endtask

  task automatic pt_write(input bit sel, input logic [5:0] addr, input logic [5:0] data);
    a_wr_en = 1'b1; a_wr_sel = sel; a_wr_addr = addr; a_wr_data = data;
    tick();
    a_wr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_rq8 = 0; a_rq32 = 0; a_wr_en = 0; a_wr_sel = 0; a_a8 = 0; a_a32 = 0;
    a_wr_addr = 0; a_wr_data = 0;
    b_rq8 = 0; b_rq32 = 0; b_wr_en = 0; b_wr_sel = 0; b_a8 = 0; b_a32 = 0;
    b_wr_addr = 0; b_wr_data = 0;

    // Reset state
    repeat (3) tick();
    check("rst_busy", {31'd0, a_busy}, 0);
    check("rst_count", {16'd0, a_cnt}, 0);
    check("rst_ret8", {20'd0, a_r8}, 0);
    check("rst_ret32", {24'd0, a_r32}, 0);
    rst_n = 1'b1;
    tick();

    // Default mapping, exact WALK_LAT=4 latency
    a_rq8 = 1; a_a8 = 6'h15;
    tick();
    check("lat_busy_after_accept", {31'd0, a_busy}, 1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("lat_no_early_complete", {31'd0, a_c8}, 0);
    end
    tick();
    check("lat_complete_at_N4", {31'd0, a_c8}, 1);
    check("default_ret8", {20'd0, a_r8}, 32'h575);
    check("count_one", {16'd0, a_cnt}, 1);
    check("ret32_untouched", {24'd0, a_r32}, 0);
    a_rq8 = 0;
    tick();
    check("pulse_one_cycle", {31'd0, a_c8}, 0);
    check("busy_cleared", {31'd0, a_busy}, 0);
    check("single_pulse_8b", n8, 1);

    // Simultaneous requests: 8B first, then 32B
    a_rq8 = 1; a_a8 = 6'h02; a_rq32 = 1; a_a32 = 4'h3;
    wait_c(0, "sim_8b_first");
    check("sim_ret8", {20'd0, a_r8}, 32'h0A2);
    check("sim_no_32b_yet", {31'd0, a_c32}, 0);
    a_rq8 = 0;
    wait_c(1, "sim_32b_second");
    check("sim_ret32", {24'd0, a_r32}, 32'h3B);
    check("sim_ret8_held", {20'd0, a_r8}, 32'h0A2);
    a_rq32 = 0;
    tick();
    tick();
    a_rq8 = 1; a_rq32 = 1;
    begin
      int k = 0;
      while (a_c8 !== 1'b1 && a_c32 !== 1'b1 && k < 40) begin
        tick();
        k++;
      end
    end
    check("rr_32b_wins_second", {30'd0, a_c32, a_c8}, 32'b10);
    a_rq32 = 0;
    wait_c(0, "rr_8b_after");
    a_rq8 = 0;
    tick();

    // No duplicate walk while RQST stays high
    base = n32;
    a_rq32 = 1; a_a32 = 4'h5;
    wait_c(1, "dup_first");
    check("dup_ret32", {24'd0, a_r32}, 32'h5D);
    repeat (20) tick();
    check("dup_one_pulse", n32 - base, 1);
    check("dup_idle", {31'd0, a_busy}, 0);
    a_rq32 = 0;
    tick();
    a_rq32 = 1;
    wait_c(1, "dup_rearm");
    tick();
    check("dup_second_walk", n32 - base, 2);
    a_rq32 = 0;
    tick();

    // Remap, plus upper write bits ignored on the 32B table
    pt_write(0, 6'h07, 6'h2A);
    pt_write(1, 6'h39, 6'h36);
    a_rq8 = 1; a_a8 = 6'h07;
    wait_c(0, "remap8");
    check("remap_ret8", {20'd0, a_r8}, 32'h1EA);
    a_rq8 = 0;
    tick();
    a_rq32 = 1; a_a32 = 4'h9;
    wait_c(1, "remap32");
    check("remap_ret32_lowbits", {24'd0, a_r32}, 32'h96);
    a_rq32 = 0;
    tick();

    // Write on the read cycle: old PPN returned; address change after accept ignored
    a_rq8 = 1; a_a8 = 6'h07;
    tick();
    a_a8 = 6'h3F;
    repeat (3) tick();
    a_wr_en = 1; a_wr_sel = 0; a_wr_addr = 6'h07; a_wr_data = 6'h11;
    tick();
    a_wr_en = 0;
    check("rbw_complete", {31'd0, a_c8}, 1);
    check("rbw_old_ppn", {20'd0, a_r8}, 32'h1EA);
    a_rq8 = 0;
    tick();
    a_rq8 = 1; a_a8 = 6'h07;
    wait_c(0, "rbw_next");
    check("rbw_new_ppn", {20'd0, a_r8}, 32'h1D1);
    a_rq8 = 0;
    tick();

    // Write in an earlier WALK cycle is visible to the walk
    a_rq8 = 1; a_a8 = 6'h07;
    tick();
    pt_write(0, 6'h07, 6'h3C);
    wait_c(0, "early_wr");
    check("early_wr_visible", {20'd0, a_r8}, 32'h1FC);
    a_rq8 = 0;
    tick();

    // Reset two cycles into a walk
    a_rq8 = 1; a_a8 = 6'h07;
    tick();
    tick();
    tick();
    base = n8;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, a_busy}, 0);
    check("midrst_ret8", {20'd0, a_r8}, 0);
    check("midrst_count", {16'd0, a_cnt}, 0);
    a_rq8 = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (8) tick();
    check("midrst_no_complete", n8 - base, 0);
    a_rq8 = 1; a_a8 = 6'h07;
    wait_c(0, "midrst_default");
    check("midrst_table_default", {20'd0, a_r8}, 32'h1E7);
    check("midrst_count_restart", {16'd0, a_cnt}, 1);
    a_rq8 = 0;
    tick();

    // WALK_LAT=1 back-to-back walks and saturating 2-bit counter
    for (int k = 0; k < 4; k++) begin
      b_rq8 = 1; b_a8 = 6'(k);
      tick();
      check("lat1_accept_busy", {31'd0, b_busy}, 1);
      check("lat1_not_yet", {31'd0, b_c8}, 0);
      tick();
      check("lat1_complete", {31'd0, b_c8}, 1);
      check("lat1_ret8", {20'd0, b_r8}, {20'd0, b_exp_ret[k]});
      check("lat1_count_sat", {30'd0, b_cnt}, {30'd0, b_exp_cnt[k]});
      b_rq8 = 0;
      tick();
      check("lat1_pulse_end", {31'd0, b_c8}, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
